// File: rtl/seq_table_loader.sv
// ----------------------------------------------------------------------------
// seq_table_loader
//
// Table-loading front end for the sequencer. TABLE_DATA writes are packed four
// at a time into 128-bit frames and stored in an internal frame memory. The
// committed TABLE_LENGTH is validated against the number of words received.
// Once the table is committed, frames are served through a registered read
// port with one cycle of latency.
//
// Optional feature macro: SEQ_LOADER_CKSUM_EN
//   When defined, table_cksum_o is the running XOR of every word accepted since
//   the last TABLE_START. When undefined, table_cksum_o is tied to zero and no
//   checksum logic is built.
//
// Parameters
//   DEPTH_LOG2        log2 of frame memory depth (capacity 4*2^DEPTH_LOG2 words)
//
// Ports
//   clk_i             system clock
//   reset_n_i         asynchronous active-low reset
//   TABLE_START       single-cycle strobe: begin a new table
//   TABLE_DATA        32-bit table word
//   TABLE_WSTB        TABLE_DATA write strobe
//   TABLE_LENGTH      table length in words
//   TABLE_LENGTH_WSTB commit strobe for TABLE_LENGTH
//   frame_addr_i      frame index to read
//   frame_rd_i        read request
//   frame_o           frame data, word0 in [31:0] ... word3 in [127:96]
//   frame_valid_o     frame_o valid (single cycle)
//   table_ready_o     table committed and readable
//   table_frames_o    committed frame count (TABLE_LENGTH/4)
//   words_written_o   words accepted since TABLE_START
//   table_err_o       sticky error until the next TABLE_START
//   table_cksum_o     XOR of accepted words (zero unless SEQ_LOADER_CKSUM_EN)
// ----------------------------------------------------------------------------
module seq_table_loader #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  TABLE_START,
   input  logic [31:0]           TABLE_DATA,
   input  logic                  TABLE_WSTB,
   input  logic [15:0]           TABLE_LENGTH,
   input  logic                  TABLE_LENGTH_WSTB,
   input  logic [DEPTH_LOG2-1:0] frame_addr_i,
   input  logic                  frame_rd_i,
   output logic [127:0]          frame_o,
   output logic                  frame_valid_o,
   output logic                  table_ready_o,
   output logic [15:0]           table_frames_o,
   output logic [15:0]           words_written_o,
   output logic                  table_err_o,
   output logic [31:0]           table_cksum_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADING = 2'd1,
      ST_READY   = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   localparam int unsigned N_FRAMES  = 2 ** DEPTH_LOG2;
   localparam logic [16:0] CAP_WORDS = 17'(4 * N_FRAMES);

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t                r_state;
   logic [15:0]           r_words;
   logic [15:0]           r_frames;
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [31:0]           r_pack0;
   logic [31:0]           r_pack1;
   logic [31:0]           r_pack2;
   logic [127:0]          r_mem [0:N_FRAMES-1];
   logic [127:0]          r_frame;
   logic                  r_frame_valid;

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   state_t                w_state_next;
   logic [1:0]            w_slot;
   logic                  w_full;
   logic                  w_overflow;
   logic                  w_accept;
   logic                  w_frame_done;
   logic [15:0]           w_words_after;
   logic                  w_len_ok;
   logic                  w_commit;
   logic                  w_rd_hit;

   // A start always restarts packing at slot 0, even when a word arrives with it.
   assign w_slot = TABLE_START ? 2'd0 : r_words[1:0];

   // The capacity check uses the count before this strobe, so the count itself
   // can never run past the memory size.
   assign w_full     = ({1'b0, r_words} == CAP_WORDS);
   assign w_overflow = TABLE_WSTB && !TABLE_START && (r_state == ST_LOADING) && w_full;

   // A word is taken either as word0 of a fresh table or while loading with room left.
   assign w_accept = TABLE_WSTB &&
                     (TABLE_START || ((r_state == ST_LOADING) && !w_full));

   assign w_frame_done = w_accept && (w_slot == 2'd3);

   // A length commit arriving with a word is compared against the count that
   // already includes that word.
   assign w_words_after = w_accept ? (r_words + 16'd1) : r_words;

   assign w_len_ok = (TABLE_LENGTH != 16'd0) &&
                     (TABLE_LENGTH[1:0] == 2'b00) &&
                     (TABLE_LENGTH == w_words_after);

   assign w_rd_hit = frame_rd_i && (r_state == ST_READY) &&
                     (16'(frame_addr_i) < r_frames);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; combinational blocks use blocking assignments.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      w_state_next = r_state;
      if (TABLE_START) begin
         w_state_next = ST_LOADING;
      end else begin
         case (r_state)
            ST_LOADING: begin
               if (w_overflow) begin
                  w_state_next = ST_ERROR;
               end else if (TABLE_LENGTH_WSTB) begin
                  w_state_next = w_len_ok ? ST_READY : ST_ERROR;
               end
            end
            ST_READY: begin
               // Writing into a committed table without a new start is an error.
               if (TABLE_WSTB) begin
                  w_state_next = ST_ERROR;
               end
            end
            default: begin
               // IDLE and ERROR only leave on TABLE_START.
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      table_ready_o = 1'b0;
      table_err_o   = 1'b0;
      w_commit      = 1'b0;
      case (r_state)
         ST_LOADING: w_commit      = TABLE_LENGTH_WSTB && !TABLE_START &&
                                     !w_overflow && w_len_ok;
         ST_READY:   table_ready_o = 1'b1;
         ST_ERROR:   table_err_o   = 1'b1;
         default:    ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Word counter, packing register, write pointer, committed frame count
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_words  <= '0;
         r_frames <= '0;
         r_wptr   <= '0;
         r_pack0  <= '0;
         r_pack1  <= '0;
         r_pack2  <= '0;
      end else begin
         if (TABLE_START) begin
            r_words  <= TABLE_WSTB ? 16'd1 : 16'd0;
            r_frames <= '0;
            r_wptr   <= '0;
         end else begin
            if (w_accept) begin
               r_words <= r_words + 16'd1;
            end
            if (w_frame_done) begin
               r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_commit) begin
               r_frames <= {2'b00, TABLE_LENGTH[15:2]};
            end
         end

         // Slot 3 completes the frame and goes straight to memory.
         if (w_accept) begin
            case (w_slot)
               2'd0:    r_pack0 <= TABLE_DATA;
               2'd1:    r_pack1 <= TABLE_DATA;
               2'd2:    r_pack2 <= TABLE_DATA;
               default: ;
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Frame memory
   // -------------------------------------------------------------------------
   // NOTE: the memory array has no reset; its contents are only ever read for
   // frames written since the last TABLE_START, and leaving it unreset lets it
   // map onto block RAM.
   always_ff @(posedge clk_i) begin
      if (w_frame_done) begin
         r_mem[r_wptr] <= {TABLE_DATA, r_pack2, r_pack1, r_pack0};
      end
   end

   // Registered read port: one cycle latency, zero data on a miss.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_frame       <= '0;
         r_frame_valid <= 1'b0;
      end else begin
         r_frame_valid <= w_rd_hit;
         r_frame       <= w_rd_hit ? r_mem[frame_addr_i] : '0;
      end
   end

   assign frame_o         = r_frame;
   assign frame_valid_o   = r_frame_valid;
   assign table_frames_o  = r_frames;
   assign words_written_o = r_words;

   // -------------------------------------------------------------------------
   // Optional running checksum
   // -------------------------------------------------------------------------
`ifdef SEQ_LOADER_CKSUM_EN
   logic [31:0] r_cksum;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cksum <= '0;
      end else if (TABLE_START) begin
         r_cksum <= TABLE_WSTB ? TABLE_DATA : 32'd0;
      end else if (w_accept) begin
         r_cksum <= r_cksum ^ TABLE_DATA;
      end
   end

   assign table_cksum_o = r_cksum;
`else
   assign table_cksum_o = 32'd0;
`endif

endmodule

// File: tb/tb_seq_table_loader.sv
// ----------------------------------------------------------------------------
// tb_seq_table_loader
//
// Drives one shared input stream into two loaders (DEPTH_LOG2 = 10 and 2) and
// compares every output after each clock edge against a behavioural model that
// keeps the current table as a plain word array.
// ----------------------------------------------------------------------------
module tb_seq_table_loader;

   localparam int BIG_LOG2 = 10;
   localparam int SML_LOG2 = 2;

   typedef enum int {M_IDLE, M_LOADING, M_READY, M_ERROR} mstate_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [31:0]  data;
   logic         wstb;
   logic [15:0]  len;
   logic         lwstb;
   logic [9:0]   addr;
   logic         rd;

   logic [127:0] frame_b,  frame_s;
   logic         valid_b,  valid_s;
   logic         ready_b,  ready_s;
   logic [15:0]  frames_b, frames_s;
   logic [15:0]  words_b,  words_s;
   logic         err_b,    err_s;
   logic [31:0]  ck_b,     ck_s;

   int total = 0;
   int bad   = 0;

   // Model state, index 0 = big instance, 1 = small instance.
   mstate_t      m_st     [2];
   int           m_words  [2];
   int           m_frames [2];
   logic [31:0]  m_ck     [2];
   logic         m_valid  [2];
   logic [127:0] m_frame  [2];
   logic [31:0]  m_tbl    [2][4096];
   int           cap      [2] = '{4096, 16};
   int           amask    [2] = '{1023, 3};

   always #5 clk = ~clk;

   seq_table_loader #(.DEPTH_LOG2(BIG_LOG2)) u_big (
      .clk_i             (clk),
      .reset_n_i         (rst_n),
      .TABLE_START       (start),
      .TABLE_DATA        (data),
      .TABLE_WSTB        (wstb),
      .TABLE_LENGTH      (len),
      .TABLE_LENGTH_WSTB (lwstb),
      .frame_addr_i      (addr),
      .frame_rd_i        (rd),
      .frame_o           (frame_b),
      .frame_valid_o     (valid_b),
      .table_ready_o     (ready_b),
      .table_frames_o    (frames_b),
      .words_written_o   (words_b),
      .table_err_o       (err_b),
      .table_cksum_o     (ck_b)
   );

   seq_table_loader #(.DEPTH_LOG2(SML_LOG2)) u_sml (
      .clk_i             (clk),
      .reset_n_i         (rst_n),
      .TABLE_START       (start),
      .TABLE_DATA        (data),
      .TABLE_WSTB        (wstb),
      .TABLE_LENGTH      (len),
      .TABLE_LENGTH_WSTB (lwstb),
      .frame_addr_i      (addr[1:0]),
      .frame_rd_i        (rd),
      .frame_o           (frame_s),
      .frame_valid_o     (valid_s),
      .table_ready_o     (ready_s),
      .table_frames_o    (frames_s),
      .words_written_o   (words_s),
      .table_err_o       (err_s),
      .table_cksum_o     (ck_s)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_st[m]     = M_IDLE;
         m_words[m]  = 0;
         m_frames[m] = 0;
         m_ck[m]     = '0;
         m_valid[m]  = 1'b0;
         m_frame[m]  = '0;
      end
   endtask

   // One clock edge, using the input values present before the edge.
   task automatic model_step();
      int a;
      bit err;
      for (int m = 0; m < 2; m++) begin
         a = int'(addr) & amask[m];
         m_valid[m] = (m_st[m] == M_READY) && rd && (a < m_frames[m]);
         m_frame[m] = '0;
         if (m_valid[m])
            m_frame[m] = {m_tbl[m][4*a+3], m_tbl[m][4*a+2], m_tbl[m][4*a+1], m_tbl[m][4*a]};

         if (start) begin
            m_st[m]     = M_LOADING;
            m_words[m]  = 0;
            m_frames[m] = 0;
            m_ck[m]     = '0;
            if (wstb) begin
               m_tbl[m][0] = data;
               m_words[m]  = 1;
               m_ck[m]     = data;
            end
         end else if (m_st[m] == M_LOADING) begin
            err = 1'b0;
            if (wstb) begin
               if (m_words[m] == cap[m]) err = 1'b1;
               else begin
                  m_tbl[m][m_words[m]] = data;
                  m_words[m]++;
                  m_ck[m] ^= data;
               end
            end
            if (lwstb && !err) begin
               if (len != 0 && (len % 4) == 0 && int'(len) == m_words[m]) begin
                  m_st[m]     = M_READY;
                  m_frames[m] = int'(len) / 4;
               end else err = 1'b1;
            end
            if (err) m_st[m] = M_ERROR;
         end else if (m_st[m] == M_READY) begin
            if (wstb) m_st[m] = M_ERROR;
         end
      end
   endtask

   task automatic check_inst(input int m, input string nm, input logic [127:0] fr,
                             input logic vl, input logic rdy, input logic [15:0] frs,
                             input logic [15:0] wds, input logic er, input logic [31:0] ck);
      logic [31:0] exp_ck;
`ifdef SEQ_LOADER_CKSUM_EN
      exp_ck = m_ck[m];
`else
      exp_ck = '0;
`endif
      check({nm, "_ready"},  128'(rdy), 128'(m_st[m] == M_READY));
      check({nm, "_err"},    128'(er),  128'(m_st[m] == M_ERROR));
      check({nm, "_words"},  128'(wds), 128'(16'(m_words[m])));
      check({nm, "_frames"}, 128'(frs), 128'(16'(m_frames[m])));
      check({nm, "_valid"},  128'(vl),  128'(m_valid[m]));
      check({nm, "_frame"},  fr,        m_frame[m]);
      check({nm, "_cksum"},  128'(ck),  128'(exp_ck));
   endtask

   task automatic check_all();
      check_inst(0, "big", frame_b, valid_b, ready_b, frames_b, words_b, err_b, ck_b);
      check_inst(1, "sml", frame_s, valid_s, ready_s, frames_s, words_s, err_s, ck_s);
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      else       model_reset();
      #1;
      check_all();
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] d);
      wstb = 1'b1; data = d; tick(); wstb = 1'b0;
   endtask

   task automatic commit(input logic [15:0] l);
      lwstb = 1'b1; len = l; tick(); lwstb = 1'b0;
   endtask

   task automatic read(input logic [9:0] a);
      rd = 1'b1; addr = a; tick(); rd = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      int l;
      logic [31:0] w;

      rst_n = 1'b0; start = 1'b0; wstb = 1'b0; lwstb = 1'b0; rd = 1'b0;
      data = '0; len = '0; addr = '0;
      model_reset();
      #2;
      check_all();
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Table of 8 words 1..8, committed, then read frame 1.
      do_start();
      for (int i = 1; i <= 8; i++) put_word(32'(i));
      commit(16'd8);
      check("t1_ready", 128'(ready_b), 128'(1'b1));
      check("t1_frames", 128'(frames_b), 128'(16'd2));
      read(10'd1);
      check("t1_frame_const", frame_b, 128'h00000008_00000007_00000006_00000005);
      check("t1_valid_const", 128'(valid_b), 128'(1'b1));
      tick();

      // Length not a multiple of four.
      do_start();
      for (int i = 0; i < 6; i++) put_word($urandom);
      commit(16'd6);
      check("t2_err", 128'(err_b), 128'(1'b1));
      read(10'd0);
      check("t2_valid", 128'(valid_b), 128'(1'b0));

      // Length mismatch, then restart clears the error.
      do_start();
      for (int i = 0; i < 4; i++) put_word($urandom);
      commit(16'd8);
      check("t3_err", 128'(err_b), 128'(1'b1));
      do_start();
      check("t3_err_clr", 128'(err_b), 128'(1'b0));
      check("t3_words_clr", 128'(words_b), 128'(16'd0));

      // Overflow of the small instance on the 17th word.
      do_start();
      for (int i = 0; i < 17; i++) put_word($urandom);
      check("t4_sml_err", 128'(err_s), 128'(1'b1));
      check("t4_sml_words", 128'(words_s), 128'(16'd16));
      commit(16'd16);

      // START+WSTB on a ready table starts a new one with that word as word0.
      do_start();
      for (int i = 0; i < 4; i++) put_word($urandom);
      commit(16'd4);
      start = 1'b1; wstb = 1'b1; data = 32'hAA; tick(); start = 1'b0; wstb = 1'b0;
      check("t5_words1", 128'(words_b), 128'(16'd1));
      for (int i = 0; i < 3; i++) put_word($urandom);
      commit(16'd4);
      read(10'd0);
      check("t5_word0", 128'(frame_b[31:0]), 128'(32'hAA));
      read(10'd1);   // addr == frame count: out of range

      // Word and length commit in the same cycle, back-to-back reads.
      do_start();
      for (int i = 0; i < 11; i++) put_word($urandom);
      wstb = 1'b1; data = $urandom; lwstb = 1'b1; len = 16'd12; tick();
      wstb = 1'b0; lwstb = 1'b0;
      check("t6_ready", 128'(ready_b), 128'(1'b1));
      rd = 1'b1;
      for (int i = 0; i < 5; i++) begin addr = 10'(i); tick(); end
      rd = 1'b0;

      // Write into a ready table.
      put_word(32'h1234);
      check("t7_err", 128'(err_b), 128'(1'b1));
      put_word(32'h5678);
      commit(16'd4);

      // Randomized tables.
      for (int t = 0; t < 14; t++) begin
         do_start();
         n = 4 * int'($urandom_range(1, 5));
         if ($urandom_range(0, 2) == 0) n += int'($urandom_range(1, 3));
         case ($urandom_range(0, 3))
            0, 1:    l = n;
            2:       l = n + 4;
            default: l = int'($urandom_range(0, 24));
         endcase
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            wstb = 1'b1; data = w;
            if (i == n - 1 && $urandom_range(0, 2) == 0) begin lwstb = 1'b1; len = 16'(l); end
            if ($urandom_range(0, 3) == 0) begin rd = 1'b1; addr = 10'($urandom_range(0, 7)); end
            tick();
            wstb = 1'b0; lwstb = 1'b0; rd = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
         end
         commit(16'(l));
         for (int i = 0; i < 6; i++) read(10'($urandom_range(0, 7)));
      end

      // Reset in the middle of a load.
      do_start();
      for (int i = 0; i < 3; i++) put_word($urandom);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      check("t8_words_rst", 128'(words_b), 128'(16'd0));
      tick();
      rst_n = 1'b1;
      put_word(32'hDEAD);
      check("t8_words_idle", 128'(words_b), 128'(16'd0));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_table_loader.md
# seq_table_loader

Table-loading front end for the sequencer block: accepts the 32-bit TABLE_DATA register write stream, packs every four words into one 128-bit frame and stores it in an internal frame memory. It validates the committed TABLE_LENGTH and serves frames to the sequencer core through a registered read port with one cycle of latency. It sits directly upstream of the sequencer, between the register bus decode and the frame-execution state machine.

## Interface
- DEPTH_LOG2, 10, log2 of frame memory depth; capacity 2^DEPTH_LOG2 frames = 4·2^DEPTH_LOG2 words
- clk_i  in  1  system clock
- reset_n_i  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- TABLE_START  in  1  single-cycle strobe: begin new table
- TABLE_DATA  in  32  table word
- TABLE_WSTB  in  1  TABLE_DATA write strobe
- TABLE_LENGTH  in  16  table length in words
- TABLE_LENGTH_WSTB  in  1  commit strobe for TABLE_LENGTH
- frame_addr_i  in  DEPTH_LOG2  frame index to read
- frame_rd_i  in  1  read request
- frame_o  out  128  frame data; word0→[31:0] … word3→[127:96]
- frame_valid_o  out  1  frame_o valid (single-cycle)
- table_ready_o  out  1  table committed and readable
- table_frames_o  out  16  committed frame count (TABLE_LENGTH/4)
- words_written_o  out  16  words accepted since TABLE_START
- table_err_o  out  1  sticky error until next TABLE_START

## Operation
- States: IDLE (after reset), LOADING, READY, ERROR.
- TABLE_START from any state → LOADING; clears words_written_o, word-in-frame counter, write frame pointer, table_frames_o, table_ready_o, table_err_o.
- LOADING, TABLE_WSTB: word stored in packing register slot (count mod 4); words_written_o +1. On 4th slot, full frame is written to memory at write pointer; pointer +1.
- LOADING, TABLE_WSTB with words_written_o = 4·2^DEPTH_LOG2 → ERROR (overflow); word discarded.
- LOADING, TABLE_LENGTH_WSTB: TABLE_LENGTH nonzero, TABLE_LENGTH[1:0]=0 and equal to words_written_o → READY, table_frames_o = TABLE_LENGTH>>2; otherwise → ERROR.
- READY, TABLE_WSTB (write without new start) → ERROR, table_ready_o drops.
- IDLE/ERROR: TABLE_WSTB and TABLE_LENGTH_WSTB ignored. READY: TABLE_LENGTH_WSTB ignored.
- Simultaneous TABLE_START + TABLE_WSTB: start applied, word accepted as word0 of new table (words_written_o = 1).
- Simultaneous TABLE_WSTB + TABLE_LENGTH_WSTB in LOADING: word counted first; length compared against incremented count.
- Read: frame_rd_i in READY with frame_addr_i < table_frames_o → frame_o = stored frame, frame_valid_o = 1 next cycle. Otherwise frame_valid_o = 0, frame_o = 0 next cycle.
- Arithmetic: words_written_o saturates never (overflow check precedes increment); all counters unsigned.

## Timing
- Reset (reset_n_i low, async): state IDLE; frame_o=0, frame_valid_o=0, table_ready_o=0, table_frames_o=0, words_written_o=0, table_err_o=0; memory contents undefined.
- words_written_o updates cycle after TABLE_WSTB.
- Memory write occurs cycle after 4th word strobe.
- table_ready_o / table_err_o assert cycle after the causing strobe.
- Read latency: 1 cycle, frame_rd_i at edge N → frame_valid_o high for edge N+1 only; back-to-back reads every cycle supported.
- Reset mid-load: table discarded, IDLE; TABLE_START required before further loading.

## Configuration
- SEQ_LOADER_CKSUM_EN defined: adds output table_cksum_o [31:0] = XOR of all accepted words since TABLE_START, updated cycle after each TABLE_WSTB, reset/cleared to 0.
- Not defined: table_cksum_o present, driven constant 0; no checksum logic.

## Test plan
- Reset release, START, 8 words 0x1…0x8, LENGTH=8 → table_ready_o=1, table_frames_o=2; read addr 1 → next cycle frame_o=0x00000008_00000007_00000006_00000005, valid=1.
- START, 6 words, LENGTH=6 → table_err_o=1, ready=0; read addr 0 → valid=0, frame_o=0.
- START, 4 words, LENGTH=8 → ERROR; new START → err=0, words_written_o=0.
- DEPTH_LOG2=2: START, 17 words → table_err_o=1 on 17th, words_written_o=16.
- START+WSTB same cycle (0xAA) after READY, then 3 words, LENGTH=4 → READY, frame word0=0xAA; with SEQ_LOADER_CKSUM_EN checksum = XOR of the 4 words.
- reset_n_i low mid-load (3 words) → all outputs 0 asynchronously; WSTB after release ignored (words_written_o stays 0).
